// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if -- request/result bundle for the muldiv_hilo HI/LO unit.
//
// Signals (as seen from the master, i.e. the requester):
//   start  out  1   request a new operation (honoured only while busy=0)
//   op     out  2   00 mult, 01 multu, 10 div, 11 divu
//   sr     out  32  multiplicand / dividend
//   tg     out  32  multiplier / divisor
//   mthi   out  1   write wdata into HI
//   mtlo   out  1   write wdata into LO
//   wdata  out  32  data for mthi/mtlo
//   busy   in   1   operation in progress
//   done   in   1   one-cycle pulse, HI/LO carry the new result
//   hi     in   32  HI register (product upper word / remainder)
//   lo     in   32  LO register (product lower word / quotient)
//   dz     in   1   sticky divide-by-zero flag of the last divide
interface muldiv_hilo_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] sr;
    logic [31:0] tg;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    modport master (
        output start, op, sr, tg, mthi, mtlo, wdata,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  start, op, sr, tg, mthi, mtlo, wdata,
        output busy, done, hi, lo, dz
    );
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo -- iterative 32x32 multiply / 32/32 divide unit with HI/LO
// result registers.
//
// Ports:
//   clk  in  rising-edge clock for all state
//   rst  in  synchronous active-high reset (priority over everything)
//   bus  muldiv_hilo_if.slave  request, mthi/mtlo and result signals
//
// Operation: an accepted start (IDLE, start=1) latches op/sr/tg, then RUN
// processes one operand bit per cycle for 32 cycles (shift-add multiply or
// restoring divide over magnitudes), and FIN presents the sign-corrected
// result on hi/lo together with a one-cycle done pulse. busy covers RUN and
// FIN. mthi/mtlo only write while the unit is idle.
//
// Configuration macro MULDIV_FAST_ZERO_EN: when defined, a multiply with a
// zero operand or a divide by zero jumps straight from the accept edge to
// FIN (busy and done both high for a single cycle). Results are identical
// either way.
module muldiv_hilo (
    input  logic         clk,
    input  logic         rst,
    muldiv_hilo_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Conditional two's-complement negate, 32 bits.
    function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Conditional two's-complement negate, 64 bits.
    function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] v);
        return neg ? (64'd0 - v) : v;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        dz_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    // Latched operation context
    logic        is_div_r;
    logic        neg_res_r;   // product / quotient must be negated
    logic        neg_rem_r;   // remainder must be negated (dividend negative)
    logic        tg_zero_r;
    logic [31:0] sr_r;
    logic [31:0] opnd_r;      // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_hi_r;    // partial product upper word / partial remainder
    logic [31:0] acc_lo_r;    // multiplier bits shifting out / quotient bits shifting in

    logic        idle_s;
    logic        accept_s;
    logic        fast_s;
    logic        last_s;
    logic        in_signed_s;
    logic        sr_neg_s;
    logic        tg_neg_s;
    logic [31:0] sr_mag_s;
    logic [31:0] tg_mag_s;

    logic [32:0] sum_s;
    logic [32:0] rem_sh_s;
    logic [31:0] sub_s;
    logic        ge_s;
    logic [31:0] step_hi_s;
    logic [31:0] step_lo_s;

    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic        wr_res_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        res_dz_s;

    // Accept / fast-path decode and operand magnitudes at the request.
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        accept_s    = idle_s && bus.start;
        last_s      = (state_r == ST_RUN) && (cnt_r == 5'd31);
        in_signed_s = ~bus.op[0];
        sr_neg_s    = in_signed_s & bus.sr[31];
        tg_neg_s    = in_signed_s & bus.tg[31];
        sr_mag_s    = cond_neg32(sr_neg_s, bus.sr);
        tg_mag_s    = cond_neg32(tg_neg_s, bus.tg);
`ifdef MULDIV_FAST_ZERO_EN
        if (bus.op[1]) begin
            fast_s = accept_s && (bus.tg == 32'd0);
        end else begin
            fast_s = accept_s && ((bus.sr == 32'd0) || (bus.tg == 32'd0));
        end
`else
        fast_s = 1'b0;
`endif
    end

    // Next-state logic of the IDLE -> RUN -> FIN -> IDLE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (fast_s) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; busy/done are registered from the next state so they
    // line up exactly with RUN/FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_FIN);
        end
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the 65-bit {carry, hi, lo} right by one.
        sum_s    = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : 33'd0);
        // Divide: bring the next dividend bit into the remainder and try to
        // subtract. The partial remainder stays below the divisor, so the
        // difference always fits in 32 bits.
        rem_sh_s = {acc_hi_r, acc_lo_r[31]};
        ge_s     = (rem_sh_s >= {1'b0, opnd_r});
        sub_s    = rem_sh_s[31:0] - opnd_r;
        if (is_div_r) begin
            if (ge_s) begin
                step_hi_s = sub_s;
                step_lo_s = {acc_lo_r[30:0], 1'b1};
            end else begin
                step_hi_s = rem_sh_s[31:0];
                step_lo_s = {acc_lo_r[30:0], 1'b0};
            end
        end else begin
            step_hi_s = sum_s[32:1];
            step_lo_s = {sum_s[0], acc_lo_r[31:1]};
        end
    end

    // Final sign correction and selection of the value written at FIN entry.
    always_comb begin
        prod_s   = cond_neg64(neg_res_r, {step_hi_s, step_lo_s});
        quo_s    = cond_neg32(neg_res_r, step_lo_s);
        rem_s    = cond_neg32(neg_rem_r, step_hi_s);
        wr_res_s = fast_s | last_s;
        if (fast_s) begin
            // Only reachable for a zero multiply or a divide by zero.
            res_dz_s = bus.op[1];
            res_hi_s = bus.op[1] ? bus.sr : 32'd0;
            res_lo_s = bus.op[1] ? 32'hFFFF_FFFF : 32'd0;
        end else if (is_div_r && tg_zero_r) begin
            res_dz_s = 1'b1;
            res_hi_s = sr_r;
            res_lo_s = 32'hFFFF_FFFF;
        end else if (is_div_r) begin
            res_dz_s = 1'b0;
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end else begin
            res_dz_s = 1'b0;
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
    end

    // Operand latch on accept and iteration datapath during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 5'd0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            tg_zero_r <= 1'b0;
            sr_r      <= 32'd0;
            opnd_r    <= 32'd0;
            acc_hi_r  <= 32'd0;
            acc_lo_r  <= 32'd0;
        end else if (accept_s) begin
            cnt_r     <= 5'd0;
            is_div_r  <= bus.op[1];
            neg_res_r <= sr_neg_s ^ tg_neg_s;
            neg_rem_r <= sr_neg_s;
            tg_zero_r <= (bus.tg == 32'd0);
            sr_r      <= bus.sr;
            acc_hi_r  <= 32'd0;
            if (bus.op[1]) begin
                opnd_r   <= tg_mag_s;
                acc_lo_r <= sr_mag_s;
            end else begin
                opnd_r   <= sr_mag_s;
                acc_lo_r <= tg_mag_s;
            end
        end else if (state_r == ST_RUN) begin
            cnt_r    <= cnt_r + 5'd1;
            acc_hi_r <= step_hi_s;
            acc_lo_r <= step_lo_s;
        end else begin
            cnt_r    <= cnt_r;
            acc_hi_r <= acc_hi_r;
            acc_lo_r <= acc_lo_r;
        end
    end

    // HI/LO/dz: result write at FIN entry wins over a coincident mthi/mtlo;
    // mthi/mtlo otherwise only write while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
            dz_r <= 1'b0;
        end else if (wr_res_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
            dz_r <= res_dz_s;
        end else begin
            if (idle_s && bus.mthi) begin
                hi_r <= bus.wdata;
            end else begin
                hi_r <= hi_r;
            end
            if (idle_s && bus.mtlo) begin
                lo_r <= bus.wdata;
            end else begin
                lo_r <= lo_r;
            end
            if (accept_s) begin
                dz_r <= 1'b0;
            end else begin
                dz_r <= dz_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.dz   = dz_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo -- self-checking bench for muldiv_hilo. Directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_muldiv_hilo;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    muldiv_hilo_if bus ();

    muldiv_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {dz, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] q64;
        logic [63:0] r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op[1] && (b == 32'd0)) return {1'b1, a, 32'hFFFF_FFFF};
        case (op)
            2'b00: begin
                r64 = sa * sb;
                return {1'b0, r64};
            end
            2'b01: begin
                r64 = ua * ub;
                return {1'b0, r64};
            end
            2'b10: begin
                q64 = sa / sb;
                r64 = sa % sb;
                return {1'b0, r64[31:0], q64[31:0]};
            end
            default: begin
                q64 = ua / ub;
                r64 = ua % ub;
                return {1'b0, r64[31:0], q64[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_busy_len(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        int len;
        len = 33;
`ifdef MULDIV_FAST_ZERO_EN
        if (op[1]) begin
            if (b == 32'd0) len = 1;
        end else begin
            if ((a == 32'd0) || (b == 32'd0)) len = 1;
        end
`endif
        return len;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called on the first negedge after the accept edge; runs to idle.
    task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        logic [64:0] exp;
        int          nbusy;
        int          ndone;
        int          done_at;
        int          guard;
        int          len;
        logic [31:0] cap_hi;
        logic [31:0] cap_lo;
        logic        cap_dz;
        exp     = ref_model(op, a, b);
        len     = exp_busy_len(op, a, b);
        nbusy   = 0;
        ndone   = 0;
        done_at = 0;
        guard   = 0;
        cap_hi  = 32'd0;
        cap_lo  = 32'd0;
        cap_dz  = 1'b0;
        while ((bus.busy === 1'b1) && (guard < 100)) begin
            nbusy++;
            if (bus.done === 1'b1) begin
                ndone++;
                done_at = nbusy;
                cap_hi  = bus.hi;
                cap_lo  = bus.lo;
                cap_dz  = bus.dz;
            end
            @(negedge clk);
            guard++;
        end
        check({tag, "_busy_len"}, 64'(nbusy), 64'(len));
        check({tag, "_done_cnt"}, 64'(ndone), 64'd1);
        check({tag, "_done_at"}, 64'(done_at), 64'(len));
        check({tag, "_hi"}, {32'd0, cap_hi}, {32'd0, exp[63:32]});
        check({tag, "_lo"}, {32'd0, cap_lo}, {32'd0, exp[31:0]});
        check({tag, "_dz"}, {63'd0, cap_dz}, {63'd0, exp[64]});
        repeat (2) @(negedge clk);
        check({tag, "_hold"}, {bus.hi, bus.lo}, exp[63:0]);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.sr    = a;
        bus.tg    = b;
        @(negedge clk);
        bus.start = 1'b0;
        // operands must have been latched; scramble the inputs
        bus.sr    = $urandom;
        bus.tg    = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
        finish_op(tag, op, a, b);
    endtask

    // mthi before a mult; second start + mtlo during RUN, mthi during FIN.
    task automatic test_ignore_busy();
        logic [64:0] exp;
        int          nbusy;
        int          ndone;
        int          hi_bad;
        int          guard;
        logic [63:0] cap;
        exp = ref_model(2'b00, 32'h0000_1234, 32'h0000_0100);
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hAAAA_0000;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_idle", {32'd0, bus.hi}, 64'h0000_0000_AAAA_0000);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.sr    = 32'h0000_1234;
        bus.tg    = 32'h0000_0100;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy  = 0;
        ndone  = 0;
        hi_bad = 0;
        guard  = 0;
        cap    = 64'd0;
        while ((bus.busy === 1'b1) && (guard < 100)) begin
            nbusy++;
            if (bus.done === 1'b1) begin
                ndone++;
                cap = {bus.hi, bus.lo};
            end else if (bus.hi !== 32'hAAAA_0000) begin
                hi_bad++;
            end
            bus.start = (nbusy == 5);
            bus.op    = 2'b11;
            bus.mtlo  = (nbusy == 5);
            bus.mthi  = (nbusy == 33);
            bus.wdata = 32'h5A5A_5A5A;
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        bus.mthi  = 1'b0;
        check("ign_busy_len", 64'(nbusy), 64'd33);
        check("ign_done_cnt", 64'(ndone), 64'd1);
        check("ign_hi_run", 64'(hi_bad), 64'd0);
        check("ign_result", cap, exp[63:0]);
        check("ign_after", {bus.hi, bus.lo}, exp[63:0]);
        @(negedge clk);
        check("ign_no_queue", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.sr    = 32'd0;
        bus.tg    = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {61'd0, bus.busy, bus.done, bus.dz}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        // idle mthi+mtlo together
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, 64'hDEAD_BEEF_DEAD_BEEF);

        do_op("mult_m1x2", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        do_op("divu_16_3", 2'b11, 32'd16, 32'd3);
        do_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0);
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("div_zero", 2'b10, 32'hFFFF_FF00, 32'd0);
        do_op("mult_zero", 2'b00, 32'd0, 32'h1234_5678);
        do_op("multu_zero", 2'b01, 32'hCAFE_0001, 32'd0);
        do_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        do_op("divu_0_5", 2'b11, 32'd0, 32'd5);

        test_ignore_busy();

        // mthi/mtlo coincident with accept take effect, result overwrites later
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.sr    = 32'd7;
        bus.tg    = 32'd9;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("coinc_write", {bus.hi, bus.lo}, 64'hCAFE_F00D_CAFE_F00D);
        finish_op("coinc_res", 2'b01, 32'd7, 32'd9);

        // reset in RUN cycle 10 aborts the operation
        do_op("dz_setup", 2'b11, 32'h1234_5678, 32'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.sr    = 32'd3;
        bus.tg    = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_flags", {61'd0, bus.busy, bus.done, bus.dz}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        begin
            int nd;
            int nb;
            nd = 0;
            nb = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.done !== 1'b0) nd++;
                if (bus.busy !== 1'b0) nb++;
            end
            check("abort_no_done", 64'(nd), 64'd0);
            check("abort_no_busy", 64'(nb), 64'd0);
        end
        do_op("after_rst", 2'b10, 32'hFFFF_FF9C, 32'd7);

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            do_op("rnd", rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 The block SHALL have no parameters; operand and result widths are fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new operation; sampled only while busy=0.
REQ-005 op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 sr  input  32  multiplicand or dividend, captured on the accept edge.
REQ-007 tg  input  32  multiplier or divisor, captured on the accept edge.
REQ-008 mthi  input  1  write wdata into HI.
REQ-009 mtlo  input  1  write wdata into LO.
REQ-010 wdata  input  32  data for mthi/mtlo.
REQ-011 busy  output  1  an operation is in progress.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
REQ-013 hi  output  32  HI register: product upper word or remainder.
REQ-014 lo  output  32  LO register: product lower word or quotient.
REQ-015 dz  output  1  sticky divide-by-zero flag for the last div/divu; cleared when the next operation is accepted.

Function
REQ-016 State machine SHALL be IDLE -> RUN -> FIN -> IDLE.
- IDLE->RUN on start=1.
- RUN lasts exactly 32 cycles, one bit per cycle.
- FIN lasts 1 cycle.
REQ-017 Accept edge: rising edge with state IDLE and start=1; sr, tg and op SHALL be latched on that edge.
REQ-018 busy SHALL be 1 from the cycle after the accept edge through the FIN cycle inclusive, i.e. 33 cycles.
REQ-019 done SHALL equal 1 only in the FIN cycle; hi and lo SHALL show the result in that cycle.
REQ-020 Multiply SHALL use shift-add over operand magnitudes and produce a 64-bit product {hi,lo}.
- mult: two's-complement negate the product when the operand signs differ.
- multu: no sign correction.
REQ-021 Divide SHALL use restoring division over magnitudes.
- div: quotient negative when operand signs differ; remainder takes the sign of the dividend.
- divu: no sign correction.
REQ-022 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no error flag.
REQ-023 Divide by zero (tg=0, div or divu) SHALL set dz=1, lo=0xFFFFFFFF, hi=latched sr.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 mthi/mtlo SHALL write on the edge only while busy=0.
- While busy=1 they SHALL be ignored.
- mthi and mtlo in the same cycle SHALL write both registers.
REQ-026 mthi/mtlo coincident with an accept edge SHALL take effect; the FIN result SHALL later overwrite hi/lo.
REQ-027 hi/lo SHALL otherwise hold their value indefinitely; they are never modified during RUN.

Reset
REQ-028 When rst=1 on an edge, the block SHALL set:
- state=IDLE
- busy=0, done=0, dz=0
- hi=0x00000000, lo=0x00000000
REQ-029 rst SHALL take priority over start, mthi and mtlo.
REQ-030 rst during RUN or FIN SHALL abort the operation, produce no done pulse, and leave hi/lo at reset values.

Configuration
REQ-031 Macro MULDIV_FAST_ZERO_EN, when defined, SHALL make FIN follow the accept edge directly, skipping RUN, when either of these holds:
- mult/multu with sr=0 or tg=0; result hi=lo=0.
- div/divu with tg=0; result per REQ-023.
In that case busy SHALL be high for 1 cycle, coincident with done.
REQ-032 When MULDIV_FAST_ZERO_EN is undefined, every operation SHALL take the full 33 busy cycles; results are identical to REQ-031.

Verification
REQ-033 mult sr=0xFFFFFFFF, tg=0x00000002 -> busy 33 cycles; done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-034 multu sr=0xFFFFFFFF, tg=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 div sr=0xFFFFFFF9 (-7), tg=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 also: divu sr=16, tg=3 -> lo=5, hi=1.
REQ-036 divu sr=0x12345678, tg=0 -> dz=1, lo=0xFFFFFFFF, hi=0x12345678.
- Busy length SHALL be 1 cycle with MULDIV_FAST_ZERO_EN defined, 33 cycles without.
REQ-037 mthi wdata=0xAAAA0000 then start mult, with a second start and mtlo pulsed during RUN.
- hi reads 0xAAAA0000 until FIN.
- mtlo and the second start are ignored.
- Exactly one done pulse occurs.
REQ-038 rst asserted in RUN cycle 10 -> next cycle busy=0, hi=lo=0, dz=0; no done; a new start is then accepted normally.
